// File: rtl/rgb_mixer_multi_pkg.sv
// rtl/rgb_mixer_multi_pkg.sv - shared limits, defaults and level-step arithmetic for the RGB mixer
package rgb_mixer_multi_pkg;

    localparam int MAX_CH         = 8;
    localparam int SEL_W          = 3;
    localparam int DEF_NW         = 8;
    localparam int DEF_DEB_CYCLES = 4;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Wrap mode relies on 32-bit underflow followed by masking to nw bits.
    function automatic int unsigned next_level(input int unsigned lvl, input int unsigned step,
                                               input dir_e dir, input bit sat,
                                               input int unsigned nw);
        int unsigned max_lvl;
        int unsigned res;
        max_lvl = (32'd1 << nw) - 32'd1;
        if (dir == DIR_UP) begin
            res = lvl + step;
            if (sat && (res > max_lvl)) res = max_lvl;
        end else if (sat && (lvl < step)) begin
            res = 32'd0;
        end else begin
            res = lvl - step;
        end
        return res & max_lvl;
    endfunction

endpackage

// File: rtl/rgb_mixer_multi_channel.sv
// rtl/rgb_mixer_multi_channel.sv - one encoder channel: sync, debounce, x1 decode, level and PWM compare
module rgb_mixer_multi_channel
    import rgb_mixer_multi_pkg::*;
#(
    parameter int NW         = DEF_NW,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int STEP       = 1,
    parameter int SATURATE   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          active,
    input  logic          enc_a,
    input  logic          enc_b,
    input  logic          load,
    input  logic [NW-1:0] load_val,
    input  logic [NW-1:0] cnt,
    output logic [NW-1:0] level,
    output logic          pwm
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    // Bit 0 carries phase A, bit 1 phase B throughout.
    logic [1:0]    meta;
    logic [1:0]    sync;
    logic [1:0]    stab;
    logic [DW-1:0] deb_cnt [2];
    logic          a_prev;
    logic          detent;
    logic [NW-1:0] stepped;

    assign detent  = stab[0] & ~a_prev;
    assign stepped = NW'(next_level(32'(level), STEP, stab[1] ? DIR_DOWN : DIR_UP,
                                    SATURATE != 0, NW));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta       <= '0;
            sync       <= '0;
            stab       <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
            a_prev     <= 1'b0;
            level      <= '0;
            pwm        <= 1'b0;
        end else begin
            meta   <= {enc_b, enc_a};
            sync   <= meta;
            a_prev <= stab[0];
            for (int i = 0; i < 2; i++) begin
                if (sync[i] == stab[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    stab[i]    <= sync[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DW'(1);
                end
            end
            // A load on the same edge as a detent overrides the step.
            if (active && load) begin
                level <= load_val;
            end else if (active && detent) begin
                level <= stepped;
            end
            pwm <= active && (cnt < level);
        end
    end

endmodule

// File: rtl/rgb_mixer_multi.sv
// rtl/rgb_mixer_multi.sv - NUM_CH encoder-driven PWM levels with shared counter and LA-bus load
module rgb_mixer_multi
    import rgb_mixer_multi_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int NW         = DEF_NW,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int STEP       = 1,
    parameter int SATURATE   = 1
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,
    input  logic                 active,
    input  logic [NUM_CH-1:0]    enc_a_i,
    input  logic [NUM_CH-1:0]    enc_b_i,
    input  logic                 load_i,
    input  logic [SEL_W-1:0]     load_sel_i,
    input  logic [NW-1:0]        load_val_i,
    output logic [NUM_CH*NW-1:0] level_o,
    output logic [NUM_CH-1:0]    pwm_o
);

    logic [NW-1:0] cnt;

    if ((NUM_CH < 1) || (NUM_CH > MAX_CH)) begin : g_bad_num_ch
        $error("rgb_mixer_multi: NUM_CH must be 1..8");
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            cnt <= '0;
        end else if (active) begin
            cnt <= cnt + NW'(1);
        end
    end

    // Select values at or above NUM_CH match no channel and fall away here.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic hit;
        assign hit = load_i && (load_sel_i == SEL_W'(c));

        rgb_mixer_multi_channel #(
            .NW         (NW),
            .DEB_CYCLES (DEB_CYCLES),
            .STEP       (STEP),
            .SATURATE   (SATURATE)
        ) u_channel (
            .clk      (wb_clk_i),
            .rst_n    (wb_rst_n_i),
            .active   (active),
            .enc_a    (enc_a_i[c]),
            .enc_b    (enc_b_i[c]),
            .load     (hit),
            .load_val (load_val_i),
            .cnt      (cnt),
            .level    (level_o[c*NW +: NW]),
            .pwm      (pwm_o[c])
        );
    end

endmodule

// File: tb/tb_rgb_mixer_multi.sv
// tb/tb_rgb_mixer_multi.sv - saturating and wrapping mixers against a behavioural model plus directed checks
module tb_rgb_mixer_multi;

    localparam int NUM_CH = 3;
    localparam int NW     = 8;
    localparam int DEB    = 4;
    localparam int STEP   = 1;
    localparam int MAXL   = 255;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 active;
    logic [NUM_CH-1:0]    enc_a;
    logic [NUM_CH-1:0]    enc_b;
    logic                 load;
    logic [2:0]           load_sel;
    logic [NW-1:0]        load_val;
    logic [NUM_CH*NW-1:0] level_s, level_w;
    logic [NUM_CH-1:0]    pwm_s, pwm_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rgb_mixer_multi #(.NUM_CH(NUM_CH), .NW(NW), .DEB_CYCLES(DEB), .STEP(STEP), .SATURATE(1)) dut_sat (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .active(active), .enc_a_i(enc_a), .enc_b_i(enc_b),
        .load_i(load), .load_sel_i(load_sel), .load_val_i(load_val), .level_o(level_s), .pwm_o(pwm_s));

    rgb_mixer_multi #(.NUM_CH(NUM_CH), .NW(NW), .DEB_CYCLES(DEB), .STEP(STEP), .SATURATE(0)) dut_wrap (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n), .active(active), .enc_a_i(enc_a), .enc_b_i(enc_b),
        .load_i(load), .load_sel_i(load_sel), .load_val_i(load_val), .level_o(level_w), .pwm_o(pwm_w));

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Model: pin seen by the debouncer two edges late; accepted after DEB differing samples.
    int  m_p;
    int  m_lvl_s [NUM_CH];
    int  m_lvl_w [NUM_CH];
    bit  m_pwm_s [NUM_CH];
    bit  m_pwm_w [NUM_CH];
    bit  h1 [NUM_CH][2];
    bit  h2 [NUM_CH][2];
    bit  stab [NUM_CH][2];
    int  run [NUM_CH][2];
    bit  aprev [NUM_CH];
    bit  hit, det;

    function automatic int model_step(input int l, input bit down, input bit sat);
        int r;
        r = down ? l - STEP : l + STEP;
        if (sat) r = (r < 0) ? 0 : ((r > MAXL) ? MAXL : r);
        else     r = (r + MAXL + 1) % (MAXL + 1);
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_p <= 0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_lvl_s[c] <= 0; m_lvl_w[c] <= 0; m_pwm_s[c] <= 0; m_pwm_w[c] <= 0; aprev[c] <= 0;
                for (int ph = 0; ph < 2; ph++) begin
                    h1[c][ph] <= 0; h2[c][ph] <= 0; stab[c][ph] <= 0; run[c][ph] <= 0;
                end
            end
        end else begin
            if (active) m_p <= (m_p + 1) % (MAXL + 1);
            for (int c = 0; c < NUM_CH; c++) begin
                hit = active && load && (int'(load_sel) == c);
                det = active && stab[c][0] && !aprev[c];
                if (hit) begin
                    m_lvl_s[c] <= int'(load_val);
                    m_lvl_w[c] <= int'(load_val);
                end else if (det) begin
                    m_lvl_s[c] <= model_step(m_lvl_s[c], stab[c][1], 1'b1);
                    m_lvl_w[c] <= model_step(m_lvl_w[c], stab[c][1], 1'b0);
                end
                m_pwm_s[c] <= active && (m_p < m_lvl_s[c]);
                m_pwm_w[c] <= active && (m_p < m_lvl_w[c]);
                aprev[c]   <= stab[c][0];
                for (int ph = 0; ph < 2; ph++) begin
                    h1[c][ph] <= (ph == 0) ? enc_a[c] : enc_b[c];
                    h2[c][ph] <= h1[c][ph];
                    if (h2[c][ph] != stab[c][ph]) begin
                        if (run[c][ph] + 1 >= DEB) begin
                            stab[c][ph] <= h2[c][ph];
                            run[c][ph]  <= 0;
                        end else begin
                            run[c][ph] <= run[c][ph] + 1;
                        end
                    end else begin
                        run[c][ph] <= 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            chk($sformatf("model_level_sat_ch%0d", c), int'(level_s[c*NW +: NW]), m_lvl_s[c]);
            chk($sformatf("model_level_wrap_ch%0d", c), int'(level_w[c*NW +: NW]), m_lvl_w[c]);
            chk($sformatf("model_pwm_sat_ch%0d", c), int'(pwm_s[c]), int'(m_pwm_s[c]));
            chk($sformatf("model_pwm_wrap_ch%0d", c), int'(pwm_w[c]), int'(m_pwm_w[c]));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int ch);
        enc_a[ch] = 1'b1; tick(8);
        enc_a[ch] = 1'b0; tick(8);
    endtask

    task automatic do_load(input int ch, input int v);
        load = 1'b1; load_sel = 3'(ch); load_val = NW'(v);
        tick(1);
        load = 1'b0;
        tick(1);
    endtask

    function automatic int lvl(input logic [NUM_CH*NW-1:0] v, input int ch);
        return int'(v[ch*NW +: NW]);
    endfunction

    task automatic count_high(input string name, input int exp);
        int n;
        n = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (pwm_s[2]) n++;
        end
        chk(name, n, exp);
    endtask

    int lat;

    initial begin
        rst_n = 1'b0; active = 1'b1; enc_a = '0; enc_b = '0;
        load = 1'b0; load_sel = '0; load_val = '0;
        tick(3);
        chk("reset_level_sat", int'(level_s), 0);
        chk("reset_pwm_sat", int'(pwm_s), 0);
        rst_n = 1'b1;
        tick(2);

        // First detent latency: sampling edge k, level at edge k+6.
        enc_a[0] = 1'b1;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (lvl(level_s, 0) != 0) begin
                lat = i - 1;
                break;
            end
        end
        chk("first_detent_latency", lat, DEB + 2);
        tick(1);
        enc_a[0] = 1'b0; tick(8);
        for (int i = 0; i < 4; i++) pulse(0);
        chk("five_pulses_ch0", lvl(level_s, 0), 5);
        chk("five_pulses_ch0_wrap", lvl(level_w, 0), 5);

        enc_a[0] = 1'b1; tick(3); enc_a[0] = 1'b0; tick(12);
        chk("glitch_3_cycles", lvl(level_s, 0), 5);
        enc_a[0] = 1'b1; tick(4); enc_a[0] = 1'b0; tick(12);
        chk("pulse_4_cycles", lvl(level_s, 0), 6);

        do_load(1, 254);
        for (int i = 0; i < 3; i++) pulse(1);
        chk("sat_up_ch1", lvl(level_s, 1), 255);
        chk("wrap_up_ch1", lvl(level_w, 1), 1);
        enc_b[1] = 1'b1; tick(10);
        do_load(1, 0);
        pulse(1);
        chk("sat_down_ch1", lvl(level_s, 1), 0);
        chk("wrap_down_ch1", lvl(level_w, 1), 255);
        enc_b[1] = 1'b0; tick(10);

        do_load(2, 64);
        count_high("pwm_duty_64", 64);
        do_load(2, 0);
        count_high("pwm_duty_0", 0);
        do_load(2, 255);
        count_high("pwm_duty_255", 255);

        // Load lands on the very edge the detent would step ch0.
        enc_a[0] = 1'b1; tick(6);
        load = 1'b1; load_sel = 3'd0; load_val = 8'd10;
        tick(1);
        load = 1'b0;
        tick(8); enc_a[0] = 1'b0; tick(10);
        chk("collision_load_wins", lvl(level_s, 0), 10);
        chk("collision_load_wins_wrap", lvl(level_w, 0), 10);

        active = 1'b0; tick(2);
        chk("inactive_pwm_sat", int'(pwm_s), 0);
        chk("inactive_pwm_wrap", int'(pwm_w), 0);
        pulse(0);
        do_load(1, 77);
        chk("inactive_detent_ignored", lvl(level_s, 0), 10);
        chk("inactive_load_ignored", lvl(level_s, 1), 0);
        enc_a[0] = 1'b1; tick(10);
        active = 1'b1; tick(10);
        chk("reenable_no_spurious", lvl(level_s, 0), 10);
        enc_a[0] = 1'b0; tick(10);
        do_load(5, 99);
        chk("sel5_ch0", lvl(level_s, 0), 10);
        chk("sel5_ch1", lvl(level_s, 1), 0);
        chk("sel5_ch2", lvl(level_s, 2), 255);

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_level", int'(level_s), 0);
        chk("async_reset_pwm", int'(pwm_s), 0);
        enc_a = '1; tick(3); enc_a = '0;
        chk("reset_held_level", int'(level_w), 0);
        rst_n = 1'b1;
        tick(10);
        pulse(2);
        chk("post_reset_detent_ch2", lvl(level_s, 2), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "timeout");
    end

endmodule
